// File: rtl/fsm_stream_ctrl_pkg.sv
// Shared definitions for the stream controller: controller and detector state codes,
// default width, and the detector transition/output table.
package fsm_stream_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CLR  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } ctrl_state_t;

    typedef enum logic [2:0] {
        DET_A = 3'b000,
        DET_B = 3'b001,
        DET_C = 3'b010,
        DET_D = 3'b011,
        DET_E = 3'b100
    } det_state_t;

    typedef struct packed {
        det_state_t next;
        logic       y;
    } det_step_t;

    // Mealy table of the sequence detector. A run of ones walks B,E,D,C,A,E,...
    // A zero returns to B, except from E where it moves to A and emits a one.
    function automatic det_step_t det_step(input det_state_t cur, input logic x);
        det_step_t s;
        s.next = DET_B;
        s.y    = 1'b0;
        case (cur)
            DET_A: begin s.next = x ? DET_E : DET_B; s.y = x;  end
            DET_B: begin s.next = x ? DET_E : DET_B; s.y = x;  end
            DET_C: begin s.next = x ? DET_A : DET_B; s.y = x;  end
            DET_D: begin s.next = x ? DET_C : DET_B; s.y = x;  end
            DET_E: begin s.next = x ? DET_D : DET_A; s.y = ~x; end
            default: begin s.next = DET_B; s.y = 1'b0; end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/c_FSM.sv
// Embedded Mealy sequence detector; asynchronous active-high reset places it in state B.
module c_FSM
    import fsm_stream_ctrl_pkg::*;
(
    output logic y_out,
    input  logic x_in,
    input  logic clk,
    input  logic reset
);

    det_state_t state_reg;
    det_state_t state_next;
    det_step_t  step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= DET_B;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        step       = det_step(state_reg, x_in);
        state_next = step.next;
        y_out      = step.y;
    end

endmodule

// File: rtl/fsm_stream_ctrl.sv
// Job controller: streams a captured pattern MSB-first through the embedded detector and
// collects its Mealy outputs into result, with popcount, per job.
module fsm_stream_ctrl
    import fsm_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [WIDTH-1:0]             pattern_in,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic                         fsm_x,
    output logic                         fsm_y
);

    localparam int CW = $clog2(WIDTH+1);

    ctrl_state_t      state_reg,   state_next;
    logic [WIDTH-1:0] shift_reg,   shift_next;
    logic [WIDTH-1:0] collect_reg, collect_next;
    logic [WIDTH-1:0] result_reg,  result_next;
    logic [CW-1:0]    ones_reg,    ones_next;
    logic [CW-1:0]    cnt_reg,     cnt_next;
    logic             clr_reg,     clr_next;

    logic [WIDTH-1:0] collect_shift;
    logic [CW-1:0]    pop_count;
    logic             det_reset;

    // Detector is cleared by the top-level reset or by the flopped per-job clear.
    assign det_reset = ~reset | clr_reg;

    c_FSM u_det (
        .y_out (fsm_y),
        .x_in  (fsm_x),
        .clk   (clk),
        .reset (det_reset)
    );

    assign collect_shift = {collect_reg[WIDTH-2:0], fsm_y};

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_count = pop_count + CW'(collect_shift[i]);
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        collect_next = collect_reg;
        result_next  = result_reg;
        ones_next    = ones_reg;
        cnt_next     = cnt_reg;
        clr_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next   = pattern_in;
                    collect_next = '0;
                    cnt_next     = '0;
                    clr_next     = 1'b1;
                    state_next   = ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_next   = '0;
                state_next = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                    collect_next = collect_shift;
                    cnt_next     = cnt_reg + CW'(1);
                    // Publish on the final capture so result is valid while done is high.
                    if (cnt_reg == CW'(WIDTH-1)) begin
                        result_next = collect_shift;
                        ones_next   = pop_count;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            collect_reg <= '0;
            result_reg  <= '0;
            ones_reg    <= '0;
            cnt_reg     <= '0;
            clr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            collect_reg <= collect_next;
            result_reg  <= result_next;
            ones_reg    <= ones_next;
            cnt_reg     <= cnt_next;
            clr_reg     <= clr_next;
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign fsm_x  = (state_reg == ST_RUN) & shift_reg[WIDTH-1];
    assign result = result_reg;
    assign ones   = ones_reg;

endmodule

// File: tb/tb_fsm_stream_ctrl.sv
// Randomized bench for fsm_stream_ctrl against a job-level reference model of the detector table.
module tb_fsm_stream_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  pattern_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [CW-1:0] ones;
    logic          fsm_x;
    logic          fsm_y;

    always #5 clk = ~clk;

    fsm_stream_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern_in (pattern_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ones       (ones),
        .fsm_x      (fsm_x),
        .fsm_y      (fsm_y)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Detector table, states indexed A=0..E=4, [state][x].
    int ns_tab [5][2] = '{'{1, 4}, '{1, 4}, '{1, 0}, '{1, 2}, '{0, 3}};
    int y_tab  [5][2] = '{'{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{1, 0}};

    logic [W-1:0] exp_result = '0;
    int           exp_ones   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Walk the detector from B over the pattern MSB-first; bit i of the return is y for bit i.
    function automatic logic [W-1:0] det_run(input logic [W-1:0] p);
        logic [W-1:0] r;
        int s;
        int x;
        r = '0;
        s = 1;
        for (int i = W - 1; i >= 0; i--) begin
            x    = int'(p[i]);
            r[i] = y_tab[s][x][0];
            s    = ns_tab[s][x];
        end
        return r;
    endfunction

    // noise: 0 none, 1 start at RUN cycles 3 and 5, 2 random start/abort where they must be ignored.
    task automatic run_job(input logic [W-1:0] p, input int abort_at, input int rst_at,
                           input int noise, input bit abort_with_start);
        logic [W-1:0] ys;
        ys         = det_run(p);
        start      = 1'b1;
        abort      = abort_with_start;
        pattern_in = p;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            check("busy_job", busy, 1);
            check("done_early", done, 0);
            check("result_hold", result, exp_result);
            if (cyc == 1) begin
                check("fsm_x_clr", fsm_x, 0);
            end else begin
                check("fsm_x_run", fsm_x, p[W-cyc+1]);
                check("fsm_y_run", fsm_y, ys[W-cyc+1]);
            end
            if (cyc == rst_at) begin
                reset = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_result", result, 0);
                check("rst_ones", ones, 0);
                check("rst_fsm_x", fsm_x, 0);
                check("rst_fsm_y", fsm_y, 0);
                exp_result = '0;
                exp_ones   = 0;
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                check("post_rst_busy", busy, 0);
                check("post_rst_done", done, 0);
                return;
            end
            pattern_in = W'($urandom);
            if (noise == 1) start = (cyc == 4 || cyc == 6);
            else if (noise == 2) start = 1'($urandom);
            abort = (cyc == abort_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_result", result, exp_result);
                check("abort_ones", ones, exp_ones);
                return;
            end
        end
        exp_result = ys;
        exp_ones   = $countones(ys);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_result", result, exp_result);
        check("done_ones", ones, exp_ones);
        check("done_fsm_x", fsm_x, 0);
        if (noise == 2) begin
            abort = 1'($urandom);
            start = 1'($urandom);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("after_result", result, exp_result);
        check("after_ones", ones, exp_ones);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pattern_in = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_ones", ones, 0);
        check("reset_fsm_x", fsm_x, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        run_job(8'hFF, 0, 0, 0, 0);
        check("ff_result_bb", result, 8'hBB);
        check("ff_ones_6", ones, 6);
        run_job(8'h00, 0, 0, 0, 0);
        check("zero_result", result, 8'h00);
        run_job(8'hFF, 0, 0, 0, 0);
        run_job(8'hFF, 0, 0, 0, 0);
        check("b2b_result_bb", result, 8'hBB);
        run_job(8'hFF, 0, 0, 1, 0);
        check("start_noise_bb", result, 8'hBB);
        run_job(8'h3C, 5, 0, 0, 0);
        check("abort_keeps_bb", result, 8'hBB);
        run_job(8'hFF, 0, 6, 0, 0);
        run_job(8'hFF, 0, 0, 0, 0);
        check("post_reset_bb", result, 8'hBB);
        run_job(8'hA5, 0, 0, 0, 1);
        run_job(8'h5A, 1, 0, 0, 0);
        run_job(8'h96, W + 1, 0, 0, 0);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        for (int j = 0; j < 40; j++) begin
            int a;
            int r;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            r = (a == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            run_job(W'($urandom), a, r, 2, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                pattern_in = W'($urandom);
                @(posedge clk); #1;
                check("gap_busy", busy, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_stream_ctrl.md
FSM_STREAM_CTRL -- requirements
Module: fsm_stream_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, number of pattern bits streamed per job (legal range 2..16).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces all registers to reset values immediately.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous job cancel; effective in CLR and RUN.
REQ-006 pattern_in  input  WIDTH  bit pattern to stream; captured on the accepting edge.
REQ-007 busy  output  1  high while a job is in CLR, RUN or DONE.
REQ-008 done  output  1  one-cycle pulse; job complete, result/ones valid.
REQ-009 result  output  WIDTH  collected Mealy outputs of the last completed job.
REQ-010 ones  output  clog2(WIDTH+1)  population count of result.
REQ-011 fsm_x  output  1  bit currently driven into the sequence-detector FSM (debug).
REQ-012 fsm_y  output  1  current Mealy output of the sequence-detector FSM (debug).

Function
REQ-013 Controller states: IDLE, CLR, RUN, DONE; encoding from the shared header.
REQ-014 IDLE: start=1 at an edge -> capture pattern_in into shift register, go to CLR; start ignored in all other states.
REQ-015 CLR: exactly one cycle; registered clear (active-high) to the embedded FSM, placing it in state B (001); then RUN, bit counter = 0.
REQ-016 RUN: fsm_x = shift register MSB; each edge captures fsm_y into collect register LSB (shift left), shifts pattern left, increments counter; FSM advances on the same edge.
REQ-017 RUN lasts exactly WIDTH cycles; after the WIDTH-th capture -> DONE.
REQ-018 DONE: one cycle; result <= collect register, ones <= its popcount, done=1; then IDLE.
REQ-019 Latency: start accepted at edge k -> done high in cycle k+WIDTH+2 (10 cycles for WIDTH=8).
REQ-020 result[WIDTH-1] holds y for pattern_in[WIDTH-1] (first streamed bit); result[0] for last.
REQ-021 result and ones change only in DONE; hold otherwise, including through abort.
REQ-022 abort=1 in CLR or RUN -> IDLE next edge, no done, result/ones unchanged; abort in IDLE/DONE ignored.
REQ-023 abort and start together in IDLE -> start accepted (abort ignored).
REQ-024 fsm_x = 0 outside RUN.
REQ-025 Every job starts the embedded FSM from state B; no state carries between jobs.
REQ-026 busy combinational from state: 1 in CLR, RUN, DONE; 0 in IDLE.

Reset
REQ-027 reset low: state IDLE, busy=0, done=0, result=0, ones=0, counter=0, shift/collect registers=0, fsm_x=0.
REQ-028 reset low also asynchronously resets the embedded FSM to state B.
REQ-029 reset mid-job aborts it; no done pulse after release; first start after release handled normally.

Structure
REQ-030 Shared header fsm_ctrl_defs.vh holds controller state encodings, embedded-FSM state codes (A=000, B=001, C=010, D=011, E=100) and default WIDTH.
REQ-031 Embedded detector instantiated as sub-module c_FSM (ports y_out, x_in, clk, reset); its reset is OR of inverted top-level reset and the registered CLR pulse.
REQ-032 CLR pulse driven directly from a flop, never from combinational logic.

Verification
REQ-033 Reset, start with pattern_in=8'hFF -> FSM path B,E,D,C,A,E,D,C; done at cycle 10; result=8'hBB, ones=6.
REQ-034 pattern_in=8'h00 -> FSM stays in B; result=8'h00, ones=0, done once.
REQ-035 Two back-to-back 8'hFF jobs (second start the cycle after done) -> both give result=8'hBB, confirming CLR per job.
REQ-036 start pulsed at RUN cycles 3 and 5 -> ignored; exactly one done; result=8'hBB.
REQ-037 abort at RUN cycle 4 after a completed 8'hFF job -> IDLE next edge, no done, result stays 8'hBB, busy=0.
REQ-038 reset low at RUN cycle 5 -> all outputs 0 immediately; after release, 8'hFF job gives result=8'hBB.
